// File: rtl/data_sram_axi_bridge.sv
// Bridges the data-cache SRAM-like handshake onto single-beat AXI3 reads and writes.
// One transaction is in flight at a time, and a non-OKAY response sets a sticky error flag.
module data_sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] req_addr_p0;
  logic [31:0] req_wdata_p0;
  logic [1:0]  req_size_p0;
  logic        req_wr_p0;
  logic        aw_done, w_done;
  logic        aw_hs, w_hs, r_hs, b_hs;
  logic        unused_ok;

  function automatic logic [3:0] strb_calc(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << lo;
      2'd1:    s = lo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Response IDs and rlast carry no information for single-beat, single-ID traffic.
  assign unused_ok = ^{rid, bid, rlast};

  assign data_addr_ok = data_req & (state == IDLE);

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign r_hs  = rvalid & rready;
  assign b_hs  = bvalid & bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_addr_p0  <= '0;
      req_wdata_p0 <= '0;
      req_size_p0  <= '0;
      req_wr_p0    <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (data_addr_ok) begin
        req_addr_p0  <= data_addr;
        req_wdata_p0 <= data_wdata;
        req_size_p0  <= data_size;
        req_wr_p0    <= data_wr;
      end
      // Handshake-done flags only live inside WR_REQ and self-clear elsewhere.
      aw_done <= (state == WR_REQ) & (aw_done | aw_hs);
      w_done  <= (state == WR_REQ) & (w_done | w_hs);
      if ((r_hs && rresp != 2'b00) || (b_hs && bresp != 2'b00))
        bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_req) state_nxt = data_wr ? WR_REQ : RD_ADDR;
      RD_ADDR: if (arready) state_nxt = RD_DATA;
      RD_DATA: if (rvalid) state_nxt = IDLE;
      WR_REQ:  if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign data_data_ok = (state == RD_DATA & rvalid & ~req_wr_p0) |
                        (state == WR_RESP & bvalid & req_wr_p0);
  assign data_rdata   = rdata;

  assign arid    = AXI_ID;
  assign araddr  = req_addr_p0;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, req_size_p0};
  assign arburst = 2'b01;
  assign arvalid = (state == RD_ADDR);
  assign rready  = (state == RD_DATA);

  assign awid    = AXI_ID;
  assign awaddr  = req_addr_p0;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, req_size_p0};
  assign awburst = 2'b01;
  assign awvalid = (state == WR_REQ) & ~aw_done;

  assign wid     = AXI_ID;
  assign wdata   = req_wdata_p0;
  assign wstrb   = strb_calc(req_size_p0, req_addr_p0[1:0]);
  assign wlast   = 1'b1;
  assign wvalid  = (state == WR_REQ) & ~w_done;
  assign bready  = (state == WR_RESP);

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge: inputs change 1ns after each rising edge, checks 1ns later.
module tb_data_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready, bus_err;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1;
  logic [3:0]  rid = 4'd1, bid = 4'd1;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00, bresp = 2'b00;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;

  int passed = 0;
  int total  = 0;
  int n_aok, n_dok;

  data_sram_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("rst_ready", {30'd0, rready, bready}, 32'd0);
    chk("rst_buserr", {31'd0, bus_err}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Word read, zero-wait slave
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEADBEEF;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1FC0_0010;
    #1;
    chk("rd_aok_T", {31'd0, data_addr_ok}, 32'd1);
    chk("rd_dok_T", {31'd0, data_data_ok}, 32'd0);
    step();
    data_req = 1'b0;
    #1;
    chk("rd_arvalid_T1", {31'd0, arvalid}, 32'd1);
    chk("rd_araddr_T1", araddr, 32'h1FC0_0010);
    chk("rd_arsize_T1", {29'd0, arsize}, 32'd2);
    chk("rd_const_T1", {arid, arlen, 2'b00, arburst, 16'd0}, {4'd1, 8'd0, 2'b00, 2'b01, 16'd0});
    chk("rd_dok_T1", {31'd0, data_data_ok}, 32'd0);
    step(); #1;
    chk("rd_dok_T2", {31'd0, data_data_ok}, 32'd1);
    chk("rd_rdata_T2", data_rdata, 32'hDEADBEEF);
    chk("rd_rready_T2", {31'd0, rready}, 32'd1);
    step(); #1;
    chk("rd_dok_T3", {31'd0, data_data_ok}, 32'd0);
    chk("rd_idle_T3", {30'd0, arvalid, rready}, 32'd0);
    arready = 1'b0; rvalid = 1'b0;

    // Byte write to offset 3, wready three cycles after awready
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
    data_addr = 32'h0000_0103; data_wdata = 32'hAB00_0000;
    awready = 1'b1; wready = 1'b0;
    #1;
    chk("wb_aok", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 1'b0;
    #1;
    chk("wb_valids_c1", {30'd0, awvalid, wvalid}, 32'd3);
    chk("wb_wstrb", {28'd0, wstrb}, 32'h8);
    chk("wb_awsize", {29'd0, awsize}, 32'd0);
    chk("wb_awaddr", awaddr, 32'h0000_0103);
    chk("wb_wdata", wdata, 32'hAB00_0000);
    chk("wb_wlast", {31'd0, wlast}, 32'd1);
    n_dok = 0;
    step(); awready = 1'b0; #1;
    chk("wb_valids_c2", {30'd0, awvalid, wvalid}, 32'd1);
    if (data_data_ok) n_dok++;
    step(); #1; if (data_data_ok) n_dok++;
    step(); wready = 1'b1; #1;
    chk("wb_wvalid_c4", {31'd0, wvalid}, 32'd1);
    if (data_data_ok) n_dok++;
    step(); wready = 1'b0; #1;
    chk("wb_resp_c5", {29'd0, awvalid, wvalid, bready}, 32'd1);
    if (data_data_ok) n_dok++;
    step(); bvalid = 1'b1; #1;
    chk("wb_dok_bvalid", {31'd0, data_data_ok}, 32'd1);
    chk("wb_dok_before", n_dok, 32'd0);
    step(); bvalid = 1'b0; #1;
    chk("wb_dok_after", {31'd0, data_data_ok}, 32'd0);
    chk("wb_bready_after", {31'd0, bready}, 32'd0);

    // Half write to offset 2, wready before awready
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
    data_addr = 32'h0000_0202; data_wdata = 32'h1234_0000;
    #1;
    chk("wh_aok", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 1'b0; wready = 1'b1; awready = 1'b0;
    #1;
    chk("wh_wstrb", {28'd0, wstrb}, 32'hC);
    chk("wh_valids_c1", {30'd0, awvalid, wvalid}, 32'd3);
    step(); wready = 1'b0; awready = 1'b1; #1;
    chk("wh_valids_c2", {30'd0, awvalid, wvalid}, 32'd2);
    chk("wh_dok_c2", {31'd0, data_data_ok}, 32'd0);
    step(); awready = 1'b0; bvalid = 1'b1; #1;
    chk("wh_valids_c3", {30'd0, awvalid, wvalid}, 32'd0);
    chk("wh_dok_c3", {31'd0, data_data_ok}, 32'd1);
    step(); bvalid = 1'b0; #1;
    chk("wh_dok_c4", {31'd0, data_data_ok}, 32'd0);

    // data_req held high across a read with 5-cycle rvalid delay
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0040;
    arready = 1'b1; rvalid = 1'b0; rdata = 32'h0BAD_F00D;
    #1;
    chk("hold_aok_T", {31'd0, data_addr_ok}, 32'd1);
    n_aok = 0; n_dok = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 7) rvalid = 1'b1;
      #1;
      if (data_addr_ok) n_aok++;
      if (data_data_ok) n_dok++;
    end
    chk("hold_aok_count", n_aok, 32'd0);
    chk("hold_dok_c7", {31'd0, data_data_ok}, 32'd1);
    chk("hold_dok_count", n_dok, 32'd1);
    step(); #1;
    chk("hold_reaccept", {31'd0, data_addr_ok}, 32'd1);
    step(); data_req = 1'b0; #1;
    step(); #1;
    chk("hold_second_dok", {31'd0, data_data_ok}, 32'd1);
    step(); rvalid = 1'b0; arready = 1'b0; #1;

    // Word write with SLVERR response
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h0000_0020; data_wdata = 32'h5555_AAAA;
    awready = 1'b1; wready = 1'b1;
    step(); data_req = 1'b0; #1;
    chk("we_wstrb", {28'd0, wstrb}, 32'hF);
    step(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10; #1;
    chk("we_dok", {31'd0, data_data_ok}, 32'd1);
    chk("we_err_pre", {31'd0, bus_err}, 32'd0);
    step(); bvalid = 1'b0; bresp = 2'b00; #1;
    chk("we_err_set", {31'd0, bus_err}, 32'd1);
    step(); step(); #1;
    chk("we_err_sticky", {31'd0, bus_err}, 32'd1);

    // Asynchronous reset while in RD_DATA
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0080;
    arready = 1'b1; rvalid = 1'b0;
    step(); data_req = 1'b0; #1;
    step(); #1;
    chk("ar_rready_pre", {31'd0, rready}, 32'd1);
    #1; rst = 1'b1; #1;
    chk("ar_ready_now", {30'd0, arvalid, rready}, 32'd0);
    chk("ar_err_clr", {31'd0, bus_err}, 32'd0);
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    #1;
    chk("ar_no_dok", {31'd0, data_data_ok}, 32'd0);
    step(); #1;
    chk("ar_no_dok_edge", {31'd0, data_data_ok}, 32'd0);
    rst = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0084;
    #1;
    chk("ar_post_aok", {31'd0, data_addr_ok}, 32'd1);
    step(); data_req = 1'b0; #1;
    chk("ar_post_araddr", araddr, 32'h0000_0084);
    step(); #1;
    chk("ar_post_dok", {31'd0, data_data_ok}, 32'd1);
    chk("ar_post_rdata", data_rdata, 32'hCAFE_F00D);
    step(); rvalid = 1'b0; arready = 1'b0; #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
